cci_rd_arbiter: RTL and testbench
=================================

Name: cci_rd_arbiter

Overview:
- Shares the CCI TX channel 0 read-request path between NUM_REQ on-chip requesters.
- Arbitrates round-robin and respects tx_c0_almostfull and lp_initdone.
- Tags each request's mdata with the requester ID and a sequence number, then routes RX channel 0 read responses back to the owning requester.
- Tracks outstanding reads per requester and provides a drain/quiesce handshake for software reset sequencing.

Parameters:
- NUM_REQ, 4: number of requesters, 1..16.
- MAX_OUTST, 32: maximum outstanding reads per requester, 1..1023.
- RDTYPE_DEFAULT, `ASE_TX0_RDLINE_S: request type used when req_type is 0.

Ports:
- clk  in  1  CCI clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- lp_initdone  in  1  link initialised; no requests are issued while low.
- req_valid  in  NUM_REQ  per-requester read request valid.
- req_addr  in  NUM_REQ*32  cache-line address, requester i at [32i+31:32i].
- req_type  in  NUM_REQ*4  request type; 0 selects RDTYPE_DEFAULT.
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- tx_c0_header  out  `CCI_TX_HDR_WIDTH  TX0 header.
- tx_c0_rdvalid  out  1  TX0 read valid.
- tx_c0_almostfull  in  1  TX0 back-pressure.
- rx_c0_header  in  `ASE_CCI_RX_HDR_WIDTH  RX0 header.
- rx_c0_data  in  `CCI_DATA_WIDTH  RX0 data.
- rx_c0_rdvalid  in  1  RX0 read response valid.
- rsp_valid  out  NUM_REQ  one-hot response strobe to the owning requester.
- rsp_data  out  `CCI_DATA_WIDTH  response data, shared by all requesters.
- rsp_tag  out  10  sequence number of the returned request.
- drain_req  in  1  stop issuing and quiesce.
- drain_done  out  1  high while in DRAINED state.
- err_unexp_rsp  out  1  sticky error: response for an invalid ID or for a requester with zero outstanding.

Behaviour:
- Reset (asynchronous, sys_reset_n low) sets:
  - all outputs to 0;
  - FSM to IDLE;
  - round-robin pointer to 0;
  - sequence counters and outstanding counters to 0.
- FSM:
  - IDLE -> RUN when lp_initdone=1.
  - RUN -> DRAIN when drain_req=1.
  - DRAIN -> DRAINED when all outstanding counters are 0.
  - DRAINED -> RUN when drain_req=0.
  - Any state -> IDLE when lp_initdone=0. Counters are held, not cleared.
- Eligibility: requester i is eligible when state=RUN, req_valid[i]=1, tx_c0_almostfull=0 and outst[i] < MAX_OUTST.
- Grant:
  - Combinational round-robin over eligible requesters, starting at the pointer.
  - req_ready[winner]=1 in the same cycle. A requester holds valid/addr/type stable until ready.
  - After a grant the pointer moves to winner+1 (mod NUM_REQ). With no grant the pointer is unchanged.
- Issue (registered, 1-cycle latency from acceptance):
  - tx_c0_rdvalid=1 the next cycle.
  - Header fields:
    - [`TX_META_TYPERANGE] = type;
    - [45:14] = addr;
    - [13:10] = requester ID;
    - [9:0] = seq[i].
  - seq[i] then increments, wrapping 1023->0.
  - tx_c0_rdvalid is otherwise 0 and the header holds its last value.
- Back-pressure: while almostfull=1, no new grants. A request already registered still issues, giving at most one beat after almostfull rises.
- Response (registered, 1-cycle latency):
  - On rx_c0_rdvalid, id = rx_c0_header[13:10].
  - If id < NUM_REQ and outst[id] > 0:
    - rsp_valid[id]=1;
    - rsp_data = rx_c0_data;
    - rsp_tag = header[9:0];
    - outst[id] decrements.
  - Otherwise the response is dropped and err_unexp_rsp is set. It is cleared only by reset.
- Outstanding counting: outst[i] increments when req_ready[i] is accepted. If an accept and a response for the same i occur in the same cycle, outst[i] is unchanged.
- drain_done deasserts in the cycle after drain_req falls.
- Responses arriving in IDLE, DRAIN or DRAINED are still routed normally.

Test Plan:
- Reset with lp_initdone=1 and req_valid=4'b1111 -> grants in order 0,1,2,3,0; tx_c0_rdvalid high for 5 consecutive cycles; header[13:10] = 0,1,2,3,0; requester 0's second header has [9:0]=1.
- Requesters 1 and 3 continuously valid, pointer at 2 -> grant 3, then 1, then 3 (alternating).
- Raise tx_c0_almostfull in the cycle of a grant -> exactly one tx_c0_rdvalid beat follows, then none until almostfull=0; no request is lost.
- MAX_OUTST=2, requester 0 issues 2 with no responses -> req_ready[0] stays 0. Return rx header[13:0]=14'h0001 -> rsp_valid=4'b0001 and rsp_tag=1 one cycle later; next cycle requester 0 is granted.
- Response with id=4'hF, NUM_REQ=4 -> no rsp_valid; err_unexp_rsp=1 and remains 1.
- 3 reads outstanding, assert drain_req -> no new grants; drain_done=1 one cycle after the 3rd response is accepted (outst reaches 0). Deassert drain_req -> drain_done=0 next cycle and grants resume.

Source files
------------

// File: rtl/cci_rd_arbiter.sv
`ifndef CCI_TX_HDR_WIDTH
`define CCI_TX_HDR_WIDTH 61
`endif
`ifndef ASE_CCI_RX_HDR_WIDTH
`define ASE_CCI_RX_HDR_WIDTH 18
`endif
`ifndef CCI_DATA_WIDTH
`define CCI_DATA_WIDTH 512
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif
`ifndef ASE_TX0_RDLINE_S
`define ASE_TX0_RDLINE_S 4'h4
`endif

// Round-robin CCI TX0 read arbiter: tags mdata with requester ID/sequence, routes RX0 responses home.
// Latency: grant in the request cycle; TX0 issue and response routing one cycle later.
// Backpressure: almostfull, a full outstanding budget or drain block grants; an already registered beat still issues.
module cci_rd_arbiter #(
    parameter int         NUM_REQ        = 4,
    parameter int         MAX_OUTST      = 32,
    parameter logic [3:0] RDTYPE_DEFAULT = `ASE_TX0_RDLINE_S
) (
    input  logic                             clk,
    input  logic                             sys_reset_n,
    input  logic                             lp_initdone,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*32-1:0]            req_addr,
    input  logic [NUM_REQ*4-1:0]             req_type,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [`CCI_TX_HDR_WIDTH-1:0]     tx_c0_header,
    output logic                             tx_c0_rdvalid,
    input  logic                             tx_c0_almostfull,
    input  logic [`ASE_CCI_RX_HDR_WIDTH-1:0] rx_c0_header,
    input  logic [`CCI_DATA_WIDTH-1:0]       rx_c0_data,
    input  logic                             rx_c0_rdvalid,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [`CCI_DATA_WIDTH-1:0]       rsp_data,
    output logic [9:0]                       rsp_tag,
    input  logic                             drain_req,
    output logic                             drain_done,
    output logic                             err_unexp_rsp
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DRAINED} state_t;

    state_t                         state, state_nxt;
    logic                           run;
    logic [IW-1:0]                  ptr, winner;
    logic                           grant_vld;
    logic [NUM_REQ-1:0]             elig;
    logic [9:0]                     seq   [NUM_REQ];
    logic [OW-1:0]                  outst [NUM_REQ];
    logic                           all_zero;
    logic [3:0]                     sel_type;
    logic [`CCI_TX_HDR_WIDTH-1:0]   hdr_nxt;
    logic [3:0]                     rx_id;
    logic [NUM_REQ-1:0]             hit;
    logic                           rsp_hit, unexp;
    logic                           rx_hdr_unused;

    assign rx_hdr_unused = ^rx_c0_header[`ASE_CCI_RX_HDR_WIDTH-1:14];

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
            if (outst[i] != '0) all_zero = 1'b0;
    end

    // Losing the link overrides every other transition; counters are left untouched.
    always_comb begin
        state_nxt = state;
        if (!lp_initdone) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     if (drain_req) state_nxt = DRAIN;
                DRAIN:   if (all_zero) state_nxt = DRAINED;
                DRAINED: if (!drain_req) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        run        = (state == RUN);
        drain_done = (state == DRAINED);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            elig[i] = run && req_valid[i] && !tx_c0_almostfull && (outst[i] < OW'(MAX_OUTST));
    end

    // Search starts at the pointer and wraps; first eligible requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                winner    = IW'(idx);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = grant_vld && (winner == IW'(i));
    end

    always_comb begin
        sel_type                     = req_type[int'(winner)*4 +: 4];
        hdr_nxt                      = '0;
        hdr_nxt[`TX_META_TYPERANGE]  = (sel_type == 4'd0) ? RDTYPE_DEFAULT : sel_type;
        hdr_nxt[45:14]               = req_addr[int'(winner)*32 +: 32];
        hdr_nxt[13:10]               = 4'(winner);
        hdr_nxt[9:0]                 = seq[winner];
    end

    // A response only counts if its owner actually has a read in flight.
    always_comb begin
        rx_id = rx_c0_header[13:10];
        for (int i = 0; i < NUM_REQ; i++)
            hit[i] = rx_c0_rdvalid && (rx_id == 4'(i)) && (outst[i] != '0);
        rsp_hit = |hit;
        unexp   = rx_c0_rdvalid && !rsp_hit;
    end

    always_ff @(posedge clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            ptr           <= '0;
            tx_c0_rdvalid <= 1'b0;
            tx_c0_header  <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            rsp_tag       <= '0;
            err_unexp_rsp <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                seq[i]   <= '0;
                outst[i] <= '0;
            end
        end else begin
            tx_c0_rdvalid <= grant_vld;
            if (grant_vld) begin
                tx_c0_header <= hdr_nxt;
                ptr          <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            rsp_valid <= hit;
            if (rsp_hit) begin
                rsp_data <= rx_c0_data;
                rsp_tag  <= rx_c0_header[9:0];
            end
            if (unexp) err_unexp_rsp <= 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) seq[i] <= seq[i] + 10'd1;
                if (req_ready[i] && !hit[i])      outst[i] <= outst[i] + 1'b1;
                else if (hit[i] && !req_ready[i]) outst[i] <= outst[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cci_rd_arbiter.sv
`timescale 1ns/1ps
`ifndef CCI_TX_HDR_WIDTH
`define CCI_TX_HDR_WIDTH 61
`endif
`ifndef ASE_CCI_RX_HDR_WIDTH
`define ASE_CCI_RX_HDR_WIDTH 18
`endif
`ifndef CCI_DATA_WIDTH
`define CCI_DATA_WIDTH 512
`endif
`ifndef TX_META_TYPERANGE
`define TX_META_TYPERANGE 55:52
`endif

// Scoreboarded bench for cci_rd_arbiter: 4 requesters, 2 outstanding reads each.
module tb_cci_rd_arbiter;

    localparam int         N     = 4;
    localparam logic [3:0] DEF_T = 4'h4;

    typedef struct packed {
        logic [N-1:0]               vld;
        logic [`CCI_DATA_WIDTH-1:0] dat;
        logic [9:0]                 tag;
    } rsp_t;

    logic                             clk = 1'b0;
    logic                             sys_reset_n, lp_initdone, tx_c0_almostfull, rx_c0_rdvalid, drain_req;
    logic [N-1:0]                     req_valid, req_ready, rsp_valid;
    logic [N*32-1:0]                  req_addr;
    logic [N*4-1:0]                   req_type;
    logic [`CCI_TX_HDR_WIDTH-1:0]     tx_c0_header;
    logic                             tx_c0_rdvalid;
    logic [`ASE_CCI_RX_HDR_WIDTH-1:0] rx_c0_header;
    logic [`CCI_DATA_WIDTH-1:0]       rx_c0_data, rsp_data;
    logic [9:0]                       rsp_tag;
    logic                             drain_done, err_unexp_rsp;

    logic [31:0]                  a      [N];
    logic [3:0]                   t      [N];
    logic [9:0]                   seq_m  [N];
    int                           outst_m[N];
    logic [N-1:0]                 bump;
    logic [`CCI_TX_HDR_WIDTH-1:0] txq [$];
    rsp_t                         rspq[$];
    logic [`CCI_TX_HDR_WIDTH-1:0] mon_h;
    rsp_t                         mon_r;
    int                           n_chk = 0, n_pass = 0, tx_beats = 0;

    always #5 clk = ~clk;

    assign req_addr = {a[3], a[2], a[1], a[0]};
    assign req_type = {t[3], t[2], t[1], t[0]};

    cci_rd_arbiter #(.NUM_REQ(N), .MAX_OUTST(2), .RDTYPE_DEFAULT(DEF_T)) dut (
        .clk(clk), .sys_reset_n(sys_reset_n), .lp_initdone(lp_initdone),
        .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type), .req_ready(req_ready),
        .tx_c0_header(tx_c0_header), .tx_c0_rdvalid(tx_c0_rdvalid), .tx_c0_almostfull(tx_c0_almostfull),
        .rx_c0_header(rx_c0_header), .rx_c0_data(rx_c0_data), .rx_c0_rdvalid(rx_c0_rdvalid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .drain_req(drain_req), .drain_done(drain_done), .err_unexp_rsp(err_unexp_rsp)
    );

    // Pops the scoreboard whenever the DUT issues a TX0 beat or routes a response.
    always @(negedge clk) begin
        if (sys_reset_n === 1'b1) begin
            if (tx_c0_rdvalid === 1'b1) begin
                tx_beats++;
                n_chk++;
                if (txq.size() == 0) $display("FAIL tx_beat unexpected hdr=%h", tx_c0_header);
                else begin
                    mon_h = txq.pop_front();
                    if (tx_c0_header !== mon_h) $display("FAIL tx_hdr got=%h exp=%h", tx_c0_header, mon_h);
                    else n_pass++;
                end
            end
            if (rsp_valid !== '0) begin
                n_chk++;
                if (rspq.size() == 0) $display("FAIL rsp unexpected vld=%b tag=%h", rsp_valid, rsp_tag);
                else begin
                    mon_r = rspq.pop_front();
                    if ({rsp_valid, rsp_data, rsp_tag} !== {mon_r.vld, mon_r.dat, mon_r.tag})
                        $display("FAIL rsp got vld=%b tag=%h data_ok=%0d exp vld=%b tag=%h",
                                 rsp_valid, rsp_tag, rsp_data === mon_r.dat, mon_r.vld, mon_r.tag);
                    else n_pass++;
                end
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (bump[i]) a[i] = a[i] + 32'd1;
        bump          = '0;
        rx_c0_rdvalid = 1'b0;
    endtask

    task automatic accept(input int w);
        logic [`CCI_TX_HDR_WIDTH-1:0] h;
        h                    = '0;
        h[`TX_META_TYPERANGE] = (t[w] == 4'd0) ? DEF_T : t[w];
        h[45:14]             = a[w];
        h[13:10]             = 4'(w);
        h[9:0]               = seq_m[w];
        txq.push_back(h);
        seq_m[w]   = seq_m[w] + 10'd1;
        outst_m[w] = outst_m[w] + 1;
        bump[w]    = 1'b1;
    endtask

    task automatic rsp_in(input logic [3:0] id, input logic [9:0] tag);
        rsp_t e;
        rx_c0_rdvalid       = 1'b1;
        rx_c0_header        = '0;
        rx_c0_header[13:10] = id;
        rx_c0_header[9:0]   = tag;
        rx_c0_data          = {16{$urandom}};
        if (int'(id) < N) begin
            if (outst_m[int'(id)] > 0) begin
                e.vld = 4'b0001 << id;
                e.dat = rx_c0_data;
                e.tag = tag;
                rspq.push_back(e);
                outst_m[int'(id)] = outst_m[int'(id)] - 1;
            end
        end
    endtask

    task automatic test_reset();
        sys_reset_n = 1'b0; lp_initdone = 1'b1; req_valid = 4'b1111; tx_c0_almostfull = 1'b0;
        drain_req = 1'b0; rx_c0_rdvalid = 1'b0; rx_c0_header = '0; rx_c0_data = '0; bump = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = {4'(i), 28'h0000100}; t[i] = (i == 2) ? 4'h6 : 4'h0; seq_m[i] = '0; outst_m[i] = 0;
        end
        repeat (2) @(negedge clk);
        #2;
        n_chk++; if ({req_ready, tx_c0_rdvalid, rsp_valid, drain_done, err_unexp_rsp} !== '0)
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, tx_c0_rdvalid, rsp_valid, drain_done, err_unexp_rsp}); else n_pass++;
        n_chk++; if (tx_c0_header !== '0) $display("FAIL reset_hdr got=%h exp=0", tx_c0_header); else n_pass++;
        n_chk++; if ({rsp_data, rsp_tag} !== '0) $display("FAIL reset_rsp tag=%h exp=0", rsp_tag); else n_pass++;
        next_cycle(); sys_reset_n = 1'b1; #2;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL idle_ready got=%b exp=0000", req_ready); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            next_cycle(); #2;
            n_chk++; if (req_ready !== (4'b0001 << (k % 4))) $display("FAIL rr_order%0d got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); else n_pass++;
            if (k > 0) begin
                n_chk++; if (tx_c0_rdvalid !== 1'b1) $display("FAIL rdvalid_run%0d got=%b exp=1", k, tx_c0_rdvalid); else n_pass++;
            end
            accept(k % 4);
        end
        next_cycle(); req_valid = 4'b0000; #2;
        n_chk++; if (tx_c0_rdvalid !== 1'b1) $display("FAIL rdvalid_last got=%b exp=1", tx_c0_rdvalid); else n_pass++;
        next_cycle(); #2;
        n_chk++; if (tx_beats !== 5) $display("FAIL beat_count got=%0d exp=5", tx_beats); else n_pass++;
    endtask

    task automatic test_max_outst();
        for (int k = 0; k < 3; k++) begin
            next_cycle(); req_valid = 4'b0001; #2;
            n_chk++; if (req_ready !== 4'b0000) $display("FAIL max_block%0d got=%b exp=0000", k, req_ready); else n_pass++;
        end
        next_cycle(); rsp_in(4'd0, 10'd1); #2;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL max_rsp_cycle got=%b exp=0000", req_ready); else n_pass++;
        next_cycle(); #2;
        n_chk++; if ({rsp_valid, rsp_tag} !== {4'b0001, 10'd1}) $display("FAIL max_rsp got vld=%b tag=%0d exp vld=0001 tag=1", rsp_valid, rsp_tag); else n_pass++;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL max_regrant got=%b exp=0001", req_ready); else n_pass++;
        accept(0);
        next_cycle(); req_valid = 4'b0000;
    endtask

    task automatic test_routing();
        logic [3:0] ids [5];
        ids = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        for (int k = 0; k < 5; k++) begin
            next_cycle(); rsp_in(ids[k], 10'(k * 37 + 2));
        end
        next_cycle(); next_cycle(); #2;
        n_chk++; if (rspq.size() !== 0) $display("FAIL route_drained got=%0d pending exp=0", rspq.size()); else n_pass++;
        n_chk++; if (err_unexp_rsp !== 1'b0) $display("FAIL route_err got=%b exp=0", err_unexp_rsp); else n_pass++;
    endtask

    task automatic test_rr_skip();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        next_cycle(); req_valid = 4'b0010; #2;
        n_chk++; if (req_ready !== 4'b0010) $display("FAIL rr_setup got=%b exp=0010", req_ready); else n_pass++;
        accept(1);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); req_valid = 4'b1010; #2;
            n_chk++; if (req_ready !== exp_seq[k]) $display("FAIL rr_alt%0d got=%b exp=%b", k, req_ready, exp_seq[k]); else n_pass++;
            accept((exp_seq[k] == 4'b1000) ? 3 : 1);
        end
        next_cycle(); req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            next_cycle(); rsp_in((k < 2) ? 4'd1 : 4'd3, 10'(k + 1));
        end
        next_cycle(); next_cycle();
    endtask

    task automatic test_almostfull();
        int beats0;
        beats0 = tx_beats;
        next_cycle(); req_valid = 4'b0001; #2;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL af_grant got=%b exp=0001", req_ready); else n_pass++;
        accept(0);
        for (int j = 0; j < 4; j++) begin
            next_cycle(); tx_c0_almostfull = 1'b1; #2;
            n_chk++; if (req_ready !== 4'b0000) $display("FAIL af_block%0d got=%b exp=0000", j, req_ready); else n_pass++;
            n_chk++; if (tx_c0_rdvalid !== (j == 0)) $display("FAIL af_beat%0d got=%b exp=%b", j, tx_c0_rdvalid, j == 0); else n_pass++;
        end
        next_cycle(); tx_c0_almostfull = 1'b0; #2;
        n_chk++; if (req_ready !== 4'b0001) $display("FAIL af_resume got=%b exp=0001", req_ready); else n_pass++;
        accept(0);
        next_cycle(); req_valid = 4'b0000; #2;
        n_chk++; if (tx_beats - beats0 !== 2) $display("FAIL af_beats got=%0d exp=2", tx_beats - beats0); else n_pass++;
        next_cycle(); rsp_in(4'd0, 10'h3);
        next_cycle(); rsp_in(4'd0, 10'h4);
        next_cycle(); next_cycle();
    endtask

    task automatic test_unexpected();
        next_cycle(); rsp_in(4'hF, 10'h3);
        next_cycle(); #2;
        n_chk++; if (rsp_valid !== 4'b0000) $display("FAIL unexp_vld got=%b exp=0000", rsp_valid); else n_pass++;
        n_chk++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_err got=%b exp=1", err_unexp_rsp); else n_pass++;
        repeat (3) next_cycle();
        #2;
        n_chk++; if (err_unexp_rsp !== 1'b1) $display("FAIL unexp_sticky got=%b exp=1", err_unexp_rsp); else n_pass++;
    endtask

    task automatic test_drain();
        for (int k = 0; k < 3; k++) begin
            next_cycle(); req_valid = 4'b0001 << k; #2;
            n_chk++; if (req_ready !== (4'b0001 << k)) $display("FAIL dr_issue%0d got=%b exp=%b", k, req_ready, 4'b0001 << k); else n_pass++;
            accept(k);
        end
        next_cycle(); req_valid = 4'b0000; drain_req = 1'b1;
        next_cycle(); req_valid = 4'b1111; #2;
        n_chk++; if (req_ready !== 4'b0000) $display("FAIL dr_block got=%b exp=0000", req_ready); else n_pass++;
        for (int j = 0; j < 3; j++) begin
            next_cycle(); rsp_in(4'(j), 10'h100 + 10'(j)); #2;
            n_chk++; if ({req_ready, drain_done} !== 5'b0) $display("FAIL dr_wait%0d got ready=%b done=%b exp 0000/0", j, req_ready, drain_done); else n_pass++;
        end
        next_cycle(); #2;
        n_chk++; if ({rsp_valid, drain_done} !== {4'b0100, 1'b0}) $display("FAIL dr_last_rsp got vld=%b done=%b exp 0100/0", rsp_valid, drain_done); else n_pass++;
        next_cycle(); #2;
        n_chk++; if ({req_ready, drain_done} !== {4'b0000, 1'b1}) $display("FAIL dr_done got ready=%b done=%b exp 0000/1", req_ready, drain_done); else n_pass++;
        next_cycle(); drain_req = 1'b0; #2;
        n_chk++; if ({req_ready, drain_done} !== {4'b0000, 1'b1}) $display("FAIL dr_hold got ready=%b done=%b exp 0000/1", req_ready, drain_done); else n_pass++;
        next_cycle(); #2;
        n_chk++; if ({req_ready, drain_done} !== {4'b1000, 1'b0}) $display("FAIL dr_resume got ready=%b done=%b exp 1000/0", req_ready, drain_done); else n_pass++;
        accept(3);
        next_cycle(); req_valid = 4'b0000;
        next_cycle(); rsp_in(4'd3, 10'h3);
        next_cycle(); next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_max_outst();
        test_routing();
        test_rr_skip();
        test_almostfull();
        test_unexpected();
        test_drain();
        #2;
        n_chk++; if (txq.size() !== 0) $display("FAIL tx_leftover got=%0d exp=0", txq.size()); else n_pass++;
        n_chk++; if (rspq.size() !== 0) $display("FAIL rsp_leftover got=%0d exp=0", rspq.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
